spi_block_slave: RTL

System-clock-domain SPI responder that receives whole AES blocks (default 16 bytes, 128 bits) from the SPI master and returns a response block on MISO in the same frame. It synchronizes `sclk`, `cs` and `mosi` into `clk` and detects edges there, so no logic runs on `sclk`. It is the AES core's side of the link: a received block is presented as one parallel word with a valid pulse, and ciphertext/plaintext is loaded back for the next block.

---
 rtl/spi_block_slave.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_block_slave.sv
// spi_block_slave
// ---------------
// SPI mode-0 block responder running entirely in the system clock domain.
// The SPI pins are oversampled through synchronizers and edge-detected on
// clk. Each completed block of W = 8*BYTES bits received on mosi is presented
// on rx_data with a one-cycle rx_valid pulse. A response block captured with
// tx_load is shifted out MSB first on miso during the next block.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   sclk, cs, mosi       SPI pins from the master (asynchronous, cs active-low)
//   miso                 serial response, 0 whenever the frame is idle
//   rx_data, rx_valid    last complete received block + one-cycle update pulse
//   tx_data, tx_load     response block and its capture strobe
//   tx_pending           a loaded response block is still waiting to be sent
//   busy                 a cs frame is in progress
//   frame_err            one-cycle pulse: frame closed on a partial block
//   dbg_state            current FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshake: rx_valid and tx_load are single-cycle strobes with no ready
// back-pressure. rx_data stays stable until the next block completes, and
// tx_load may be issued at any time; a later load overwrites an unsent one.

module spi_block_slave #(
    parameter int BYTES = 16,
    parameter int CNT_W = $clog2(8 * BYTES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 miso,
    output logic [8*BYTES-1:0]   rx_data,
    output logic                 rx_valid,
    input  logic [8*BYTES-1:0]   tx_data,
    input  logic                 tx_load,
    output logic                 tx_pending,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 dbg_state
);

    localparam int W = 8 * BYTES;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchronizer chains. cs resets low in every stage, so a cs already
    // held low when reset releases never looks like a falling edge.
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_s3_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= cs;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign cs_rise   = cs_s2_q & ~cs_s3_q;
    assign cs_fall   = ~cs_s2_q & cs_s3_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             blk_done_q, blk_done_d;
    logic [W-1:0]     rx_shift_q, rx_shift_d;
    logic [W-1:0]     rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [W-1:0]     tx_buf_q, tx_buf_d;
    logic             tx_pending_q, tx_pending_d;
    logic [W-1:0]     tx_shift_q, tx_shift_d;
    logic             blk_start;
    logic [W-1:0]     rx_next;

    assign rx_next = {rx_shift_q[W-2:0], mosi_s2_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            blk_done_q   <= 1'b0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_buf_q     <= '0;
            tx_pending_q <= 1'b0;
            tx_shift_q   <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            blk_done_q   <= blk_done_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            tx_buf_q     <= tx_buf_d;
            tx_pending_q <= tx_pending_d;
            tx_shift_q   <= tx_shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        blk_done_d   = blk_done_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        tx_buf_d     = tx_buf_q;
        tx_pending_d = tx_pending_q;
        tx_shift_d   = tx_shift_q;
        blk_start    = 1'b0;

        if (tx_load) begin
            tx_buf_d     = tx_data;
            tx_pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    blk_done_d = 1'b0;
                    rx_shift_d = '0;
                    blk_start  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // cs has priority over an sclk edge seen in the same cycle.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    blk_done_d  = 1'b0;
                    rx_shift_d  = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == CNT_W'(W - 1)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        blk_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // The fall that closes a block presents bit 0 of the next
                    // response instead of shifting, so blocks run gap-free.
                    if (blk_done_q) begin
                        blk_start  = 1'b1;
                        blk_done_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load landing on the block start bypasses the buffer.
        if (blk_start) begin
            if (tx_load) begin
                tx_shift_d   = tx_data;
                tx_pending_d = 1'b0;
            end else if (tx_pending_q) begin
                tx_shift_d   = tx_buf_q;
                tx_pending_d = 1'b0;
            end else begin
                tx_shift_d = '0;
            end
        end
    end

    assign busy       = (state_q == ST_ACTIVE);
    assign miso       = busy ? tx_shift_q[W-1] : 1'b0;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_pending = tx_pending_q;
    assign frame_err  = frame_err_q;
    assign dbg_state  = state_q;

endmodule
